mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : Single-outstanding memory access controller sitting between an
//            instruction-fetch / load-store requester and a synchronous-read
//            memory. Each accepted request walks IDLE -> ISSUE -> WAIT -> RESP.
//            Loads capture the memory read data into the instruction register
//            (fetch) or the memory data register (data load). Illegal accesses
//            take the same path and latency but never touch the memory and
//            come back with resp_err set.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_WIDTH : data word width (default 32)
//   ADDR_WIDTH : byte address width (default 32); MSB=1 data region,
//                MSB=0 instruction region
// Ports
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_fetch, req_wr   : access kind (fetch / store)
//   req_addr, req_wr_data : request address and store data
//   resp_valid/resp_ready : response handshake, resp_err flags rejection
//   mem_chip_sel, mem_addr, mem_wr_data, mem_wr_en : memory command side
//   mem_rd_data         : memory read data, one cycle after the address
//   instr_reg, mem_data_reg : load destination registers
// Configuration macro
//   MEM_ACCESS_ALIGN_CHECK_EN : when defined, a non-word-aligned address
//                               (req_addr[1:0] != 0) is also illegal
// ============================================================================
module mem_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_fetch,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wr_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_err,
  output logic                  mem_chip_sel,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] instr_reg,
  output logic [DATA_WIDTH-1:0] mem_data_reg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                state_q,   state_d;
  logic                  fetch_q,   fetch_d;
  logic                  wr_q,      wr_d;
  logic                  illegal_q, illegal_d;
  logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
  logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
  logic [DATA_WIDTH-1:0] instr_q,   instr_d;
  logic [DATA_WIDTH-1:0] mdr_q,     mdr_d;

  logic w_accept;
  logic w_region_data;
  logic w_misalign;
  logic w_illegal;

  assign w_accept      = req_valid && (state_q == S_IDLE);
  assign w_region_data = req_addr[ADDR_WIDTH-1];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign w_misalign = |req_addr[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  // Fetches must target the instruction region and may never write;
  // stores must target the data region. Data loads may read either region.
  assign w_illegal = (req_fetch && w_region_data)
                   || (req_fetch && req_wr)
                   || (!req_fetch && req_wr && !w_region_data)
                   || w_misalign;

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    fetch_d   = fetch_q;
    wr_d      = wr_q;
    illegal_d = illegal_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    instr_d   = instr_q;
    mdr_d     = mdr_q;

    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_err     = 1'b0;
    mem_chip_sel = 1'b0;
    mem_wr_en    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          fetch_d   = req_fetch;
          wr_d      = req_wr;
          illegal_d = w_illegal;
          addr_d    = req_addr;
          wdata_d   = req_wr_data;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        mem_chip_sel = !illegal_q;
        // Single-cycle write strobe: the memory commits the store on the
        // ISSUE->WAIT edge, WAIT only keeps the chip selected.
        mem_wr_en    = !illegal_q && wr_q;
        state_d      = S_WAIT;
      end

      S_WAIT: begin
        mem_chip_sel = !illegal_q;
        // Read data presented during ISSUE is valid now; capture on exit.
        if (!illegal_q && !wr_q) begin
          if (fetch_q) begin
            instr_d = mem_rd_data;
          end else begin
            mdr_d = mem_rd_data;
          end
        end
        state_d = S_RESP;
      end

      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = illegal_q;
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fetch_q   <= 1'b0;
      wr_q      <= 1'b0;
      illegal_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      instr_q   <= '0;
      mdr_q     <= '0;
    end else begin
      state_q   <= state_d;
      fetch_q   <= fetch_d;
      wr_q      <= wr_d;
      illegal_q <= illegal_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      instr_q   <= instr_d;
      mdr_q     <= mdr_d;
    end
  end

  // Memory address/data follow the latched request so they hold their last
  // value outside ISSUE/WAIT; chip select and write enable gate their use.
  assign mem_addr     = addr_q;
  assign mem_wr_data  = wdata_q;
  assign instr_reg    = instr_q;
  assign mem_data_reg = mdr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Self-checking bench for mem_access_ctrl. A table of directed
//            access vectors is applied in order with hand-computed expected
//            register contents, followed by hand-written sequences for
//            response back-pressure, reset during ISSUE and the optional
//            alignment check (MEM_ACCESS_ALIGN_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_fetch;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wr_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic        mem_chip_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_en;
  logic [31:0] mem_rd_data;
  logic [31:0] instr_reg;
  logic [31:0] mem_data_reg;

  mem_access_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_fetch    (req_fetch),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wr_data  (req_wr_data),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_err     (resp_err),
    .mem_chip_sel (mem_chip_sel),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_en    (mem_wr_en),
    .mem_rd_data  (mem_rd_data),
    .instr_reg    (instr_reg),
    .mem_data_reg (mem_data_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Synchronous-read memory model with fixed preload contents
  // --------------------------------------------------------------------------
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] preload(input logic [31:0] a);
    case (a)
      32'h0000_0004: preload = 32'h8C01_0000;
      32'h8000_0030: preload = 32'h1234_5678;
      32'h0000_0100: preload = 32'hCAFE_F00D;
      32'h8000_0002: preload = 32'h0BAD_CAFE;
      default:       preload = 32'h0000_0000;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_chip_sel) begin
      if (mem_wr_en) mem[mem_addr] = mem_wr_data;
      mem_rd_data <= mem.exists(mem_addr) ? mem[mem_addr] : preload(mem_addr);
    end
  end

  // Running totals of chip-select and write-enable cycles
  int cs_tot = 0;
  int we_tot = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_chip_sel) cs_tot = cs_tot + 1;
      if (mem_wr_en)    we_tot = we_tot + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Checking helpers
  // --------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fetch;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_instr;
    logic [31:0] exp_mdr;
    int          exp_cs;
    int          exp_we;
  } vec_t;

  // One full transaction, entered and left at a negedge while in IDLE.
  // Stimulus changes at negedges; DUT outputs sampled at negedges.
  task automatic run_vec(input vec_t v, input string tag);
    int cs0;
    int we0;
    chk({tag, ".idle_ready"}, {31'd0, req_ready}, 32'd1);
    cs0         = cs_tot;
    we0         = we_tot;
    req_valid   = 1'b1;
    req_fetch   = v.fetch;
    req_wr      = v.wr;
    req_addr    = v.addr;
    req_wr_data = v.wdata;
    @(negedge clk); // ISSUE (accepted on edge N)
    chk({tag, ".issue_ready"}, {31'd0, req_ready}, 32'd0);
    chk({tag, ".issue_addr"}, mem_addr, v.addr);
    if (v.wr) chk({tag, ".issue_wdata"}, mem_wr_data, v.wdata);
    // Busy-time request changes must be ignored
    req_fetch   = ~v.fetch;
    req_wr      = ~v.wr;
    req_addr    = 32'h5555_5554;
    req_wr_data = 32'h0F0F_0F0F;
    @(negedge clk); // WAIT
    chk({tag, ".wait_rvalid"}, {31'd0, resp_valid}, 32'd0);
    @(negedge clk); // RESP: resp_valid seen at edge N+3
    chk({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, ".resp_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
    chk({tag, ".instr_reg"}, instr_reg, v.exp_instr);
    chk({tag, ".mem_data_reg"}, mem_data_reg, v.exp_mdr);
    chk({tag, ".cs_cycles"}, cs_tot - cs0, v.exp_cs);
    chk({tag, ".we_pulses"}, we_tot - we0, v.exp_we);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk); // back in IDLE
    chk({tag, ".done_rvalid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, ".done_ready"}, {31'd0, req_ready}, 32'd1);
    resp_ready = 1'b0;
  endtask

  vec_t vecs [11];

  initial begin
    vec_t v;
    int   cs0;
    int   we0;
    logic seen_rv;

    // Expected register contents accumulate from vector to vector.
    //              fetch wr    addr          wdata         err   instr         mdr           cs we
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 1'b0, 32'h8C01_0000, 32'h0000_0000, 2, 0};
    vecs[1]  = '{1'b0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h8C01_0000, 32'h0000_0000, 2, 1};
    vecs[2]  = '{1'b0, 1'b0, 32'h8000_0010, 32'h0000_0000, 1'b0, 32'h8C01_0000, 32'hDEAD_BEEF, 2, 0};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1111_2222, 1'b1, 32'h8C01_0000, 32'hDEAD_BEEF, 0, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'h8000_0030, 32'h0000_0000, 1'b1, 32'h8C01_0000, 32'hDEAD_BEEF, 0, 0};
    vecs[5]  = '{1'b1, 1'b1, 32'h0000_0100, 32'h3333_4444, 1'b1, 32'h8C01_0000, 32'hDEAD_BEEF, 0, 0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 32'hDEAD_BEEF, 2, 0};
    vecs[7]  = '{1'b0, 1'b0, 32'h8000_0030, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 32'h1234_5678, 2, 0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 2, 0};
    vecs[9]  = '{1'b0, 1'b1, 32'h8000_0030, 32'hA5A5_A5A5, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 2, 1};
    vecs[10] = '{1'b0, 1'b0, 32'h8000_0030, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 32'hA5A5_A5A5, 2, 0};

    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_fetch   = 1'b0;
    req_wr      = 1'b0;
    req_addr    = 32'h0;
    req_wr_data = 32'h0;
    resp_ready  = 1'b0;

    // ---- Reset state ----
    repeat (3) @(negedge clk);
    chk("rst.resp_valid",   {31'd0, resp_valid},   32'd0);
    chk("rst.resp_err",     {31'd0, resp_err},     32'd0);
    chk("rst.chip_sel",     {31'd0, mem_chip_sel}, 32'd0);
    chk("rst.wr_en",        {31'd0, mem_wr_en},    32'd0);
    chk("rst.mem_addr",     mem_addr,              32'd0);
    chk("rst.mem_wr_data",  mem_wr_data,           32'd0);
    chk("rst.instr_reg",    instr_reg,             32'd0);
    chk("rst.mem_data_reg", mem_data_reg,          32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.req_ready", {31'd0, req_ready}, 32'd1);

    // ---- Table-driven vectors ----
    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // ---- Back-pressure: load held in RESP for 5 cycles ----
    req_valid   = 1'b1;
    req_fetch   = 1'b0;
    req_wr      = 1'b0;
    req_addr    = 32'h8000_0010;
    req_wr_data = 32'h0;
    @(negedge clk); // ISSUE
    req_valid = 1'b0;
    @(negedge clk); // WAIT
    @(negedge clk); // RESP
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d.resp_valid", k), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d.resp_err", k),   {31'd0, resp_err},   32'd0);
      chk($sformatf("bp%0d.mdr", k),        mem_data_reg,        32'hDEAD_BEEF);
      chk($sformatf("bp%0d.req_ready", k),  {31'd0, req_ready},  32'd0);
      chk($sformatf("bp%0d.mem_addr", k),   mem_addr,            32'h8000_0010);
      // A request offered while in RESP must not be taken
      req_valid = 1'b1;
      req_fetch = 1'b1;
      req_addr  = 32'h0000_0004;
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp.idle_ready",  {31'd0, req_ready},  32'd1);
    chk("bp.idle_rvalid", {31'd0, resp_valid}, 32'd0);
    chk("bp.instr_keep",  instr_reg,           32'hCAFE_F00D);
    resp_ready = 1'b0;

    // ---- Reset asserted during ISSUE of a store ----
    req_valid   = 1'b1;
    req_fetch   = 1'b0;
    req_wr      = 1'b1;
    req_addr    = 32'h8000_0020;
    req_wr_data = 32'hBEEF_0001;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("rstiss.we_before", {31'd0, mem_wr_en}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstiss.wr_en",     {31'd0, mem_wr_en},    32'd0);
    chk("rstiss.chip_sel",  {31'd0, mem_chip_sel}, 32'd0);
    chk("rstiss.resp_valid",{31'd0, resp_valid},   32'd0);
    chk("rstiss.mem_addr",  mem_addr,              32'd0);
    chk("rstiss.wdata",     mem_wr_data,           32'd0);
    chk("rstiss.instr",     instr_reg,             32'd0);
    chk("rstiss.mdr",       mem_data_reg,          32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    seen_rv = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) seen_rv = 1'b1;
    end
    chk("rstiss.no_resp",  {31'd0, seen_rv},   32'd0);
    chk("rstiss.ready",    {31'd0, req_ready}, 32'd1);
    chk("rstiss.no_write", {31'd0, mem.exists(32'h8000_0020)}, 32'd0);

    // ---- Misaligned data load ----
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    v = '{1'b0, 1'b0, 32'h8000_0002, 32'h0, 1'b1, 32'h0, 32'h0, 0, 0};
`else
    v = '{1'b0, 1'b0, 32'h8000_0002, 32'h0, 1'b0, 32'h0, 32'h0BAD_CAFE, 2, 0};
`endif
    run_vec(v, "misalign");

    cs0 = cs_tot;
    we0 = we_tot;
    repeat (3) @(negedge clk);
    chk("idle.no_cs", cs_tot - cs0, 32'd0);
    chk("idle.no_we", we_tot - we0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
